// File: rtl/mii_tx_pkg.sv
// mii_tx_pkg: shared types and constants for the MII transmit framer.
//   tx_state_t  framer FSM states
//   preamble/SFD nibbles, preamble length
//   CRC-32 (reflected) polynomial/seed and a one-nibble update function
package mii_tx_pkg;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} tx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB    = 4'h5;
  localparam logic [3:0]  SFD_NIB         = 4'hD;
  localparam int          PREAMBLE_CYCLES = 16;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

  // Reflected CRC: the nibble enters LSB first, matching MII bit order.
  function automatic logic [31:0] crc32_nib(input logic [31:0] crc, input logic [3:0] nib);
    logic [31:0] c;
    c = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_nibble.sv
// crc32_nibble: combinational CRC-32 step over one 4-bit nibble.
//   crc      in  32  running CRC
//   nib      in  4   nibble (bit 0 is first on the wire)
//   crc_next out 32  updated CRC
module crc32_nibble
  import mii_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next
);

  assign crc_next = crc32_nib(crc, nib);

endmodule

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: valid/ready byte stream -> MII transmit nibbles.
// Adds preamble/SFD, zero-pads short frames, optionally appends FCS,
// and holds the inter-frame gap. Single clock domain (eth_tx_clk).
// Build option: define MII_TX_FCS_EN to generate and append CRC-32 FCS;
// otherwise the source is expected to supply its own FCS bytes.
// Ports:
//   eth_tx_clk          PHY transmit clock
//   rstn                async active-low reset
//   s_data/valid/last   payload byte stream in; s_ready accepts
//   eth_tx_en/eth_txd   registered MII transmit pins
//   tx_busy             FSM not idle
//   tx_done             pulse on last nibble of a completed frame
//   tx_abort            pulse on first cycle after an underrun/oversize cut
//   frame_cnt           completed-frame counter (wraps)
module mii_tx_framer
  import mii_tx_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514,
  parameter int IFG_NIBBLES     = 24
) (
  input  logic        eth_tx_clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        eth_tx_en,
  output logic [3:0]  eth_txd,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_abort,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_CYCLES - 1);
  localparam logic [7:0]  PRE_SFD  = 8'(PREAMBLE_CYCLES - 2);
  // The mandatory IDLE cycle also has eth_tx_en low, so IFG itself lasts
  // one cycle less; back-to-back frames then see exactly IFG_NIBBLES low.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_NIBBLES - 2);
  localparam logic [10:0] MIN_B    = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_B    = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] PAD_LAST = 11'(MIN_FRAME_BYTES - 1);

`ifdef MII_TX_FCS_EN
  localparam tx_state_t TAIL = FCS;
`else
  localparam tx_state_t TAIL = IFG;
`endif

  tx_state_t   state, state_nxt;
  logic [7:0]  cnt;
  logic        nib_hi;
  logic [10:0] byte_cnt;
  logic [7:0]  data_q;
  logic        last_q;
  logic        accept, pre_last, byte_end, pad_end, need_pad, oversize, abort_d;
  logic        tx_en_d;
  logic [3:0]  txd_d;

  assign accept   = s_valid && s_ready;
  assign pre_last = (state == PREAMBLE) && (cnt == PRE_LAST);
  assign byte_end = (state == DATA) && nib_hi;
  assign pad_end  = (state == PAD) && nib_hi && (byte_cnt == PAD_LAST);
  assign need_pad = byte_cnt < MIN_B;
  assign oversize = byte_end && !last_q && (byte_cnt == MAX_B);
  assign abort_d  = (s_ready && !s_valid) || oversize;

  // state register
  always_ff @(posedge eth_tx_clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (s_valid) state_nxt = PREAMBLE;
      PREAMBLE: if (pre_last) state_nxt = s_valid ? DATA : IFG;
      DATA:
        if (nib_hi) begin
          if (last_q)       state_nxt = need_pad ? PAD : TAIL;
          else if (abort_d) state_nxt = IFG;
        end
      PAD:      if (pad_end) state_nxt = TAIL;
      FCS:      if (cnt == 8'd7) state_nxt = IFG;
      IFG:      if (cnt == IFG_LAST) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

`ifdef MII_TX_FCS_EN
  logic [31:0] crc_q, crc_upd;

  crc32_nibble u_crc (.crc(crc_q), .nib(txd_d), .crc_next(crc_upd));

  // CRC tracks each data/pad nibble as it is registered onto the pins, so
  // it is complete by the time FCS starts; during FCS it shifts out.
  always_ff @(posedge eth_tx_clk or negedge rstn)
    if (!rstn)                                        crc_q <= '0;
    else if (state == IDLE)                           crc_q <= CRC_INIT;
    else if (state_nxt == DATA || state_nxt == PAD)   crc_q <= crc_upd;
    else if (state == FCS)                            crc_q <= crc_q >> 4;
`endif

  // outputs: strobes from current state, pin values for the next cycle
  always_comb begin
    s_ready = pre_last || (byte_end && !last_q && (byte_cnt != MAX_B));
    tx_busy = (state != IDLE);
`ifdef MII_TX_FCS_EN
    tx_done = (state == FCS) && (cnt == 8'd7);
`else
    tx_done = (byte_end && last_q && !need_pad) || pad_end;
`endif
    tx_en_d = 1'b0;
    txd_d   = 4'h0;
    case (state_nxt)
      PREAMBLE: begin
        tx_en_d = 1'b1;
        txd_d   = (state == PREAMBLE && cnt == PRE_SFD) ? SFD_NIB : PREAMBLE_NIB;
      end
      DATA: begin
        tx_en_d = 1'b1;
        txd_d   = accept ? s_data[3:0] : data_q[7:4];
      end
      PAD: tx_en_d = 1'b1;
`ifdef MII_TX_FCS_EN
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = (state == FCS) ? ~crc_q[7:4] : ~crc_q[3:0];
      end
`endif
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge eth_tx_clk or negedge rstn)
    if (!rstn) begin
      cnt       <= '0;
      nib_hi    <= 1'b0;
      byte_cnt  <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      eth_tx_en <= 1'b0;
      eth_txd   <= '0;
      tx_abort  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      cnt    <= (state_nxt == state) ? cnt + 8'd1 : 8'd0;
      nib_hi <= (state_nxt == state) && !nib_hi;
      if (state == IDLE) begin
        byte_cnt <= '0;
        last_q   <= 1'b0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 11'd1;
        data_q   <= s_data;
        last_q   <= s_last;
      end else if (state == PAD && nib_hi) begin
        byte_cnt <= byte_cnt + 11'd1;
      end
      eth_tx_en <= tx_en_d;
      eth_txd   <= txd_d;
      tx_abort  <= abort_d;
      if (tx_done) frame_cnt <= frame_cnt + 16'd1;
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: directed self-checking bench for mii_tx_framer.
// Expectations follow the MII_TX_FCS_EN build option of the compile.
module tb_mii_tx_framer;

  logic        eth_tx_clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready, eth_tx_en, tx_busy, tx_done, tx_abort;
  logic [3:0]  eth_txd;
  logic [15:0] frame_cnt;

  mii_tx_framer dut (
    .eth_tx_clk(eth_tx_clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .eth_tx_en(eth_tx_en), .eth_txd(eth_txd),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_abort(tx_abort), .frame_cnt(frame_cnt)
  );

  always #20 eth_tx_clk = ~eth_tx_clk;

  int n_chk = 0, n_fail = 0, exp_frames = 0;
  logic tr_en[$], tr_rdy[$], tr_done[$], tr_abort[$];
  logic [3:0] nibs[$], exp_n[$];
  logic [7:0] base;
  bit timed_out;
  int en_cycles, done_cnt, abort_cnt, rdy_cnt, rdy_bad, last_en, done_idx, abort_idx, tail_low, gap;

`ifdef MII_TX_FCS_EN
  localparam int FCS_NIBS = 8;
`else
  localparam int FCS_NIBS = 0;
`endif

  // Expected wire nibbles: preamble, payload base+i, zero pad to 60, FCS.
  function automatic void build_exp(input int len);
    logic [7:0] fr[$];
    logic [31:0] c;
    exp_n.delete();
    for (int i = 0; i < 15; i++) exp_n.push_back(4'h5);
    exp_n.push_back(4'hD);
    for (int i = 0; i < len; i++) fr.push_back(8'(base + i));
    while (fr.size() < 60) fr.push_back(8'h00);
    foreach (fr[i]) begin
      exp_n.push_back(fr[i][3:0]);
      exp_n.push_back(fr[i][7:4]);
    end
    c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      c = c ^ {24'd0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int k = 0; k < FCS_NIBS; k++) exp_n.push_back(c[4*k +: 4]);
  endfunction

  function automatic int nib_errs();
    int e = 0;
    if (nibs.size() != exp_n.size()) e++;
    for (int i = 0; i < nibs.size() && i < exp_n.size(); i++)
      if (nibs[i] !== exp_n[i]) e++;
    return e;
  endfunction

  // Source driver + trace recorder. Inputs change 1 time unit after the
  // rising edge; outputs are sampled on the falling edge.
  task automatic drive(input int nfr, input int len, input int stop_after, input int budget);
    int idx = 0, fr = 0, ended = 0, prev = -1;
    bit acc, fin = 0;
    tr_en.delete(); tr_rdy.delete(); tr_done.delete(); tr_abort.delete(); nibs.delete();
    s_valid = 1'b1; s_data = base; s_last = (len == 1);
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge eth_tx_clk);
      tr_en.push_back(eth_tx_en); tr_rdy.push_back(s_ready);
      tr_done.push_back(tx_done); tr_abort.push_back(tx_abort);
      if (eth_tx_en) nibs.push_back(eth_txd);
      if (tx_done || tx_abort) ended++;
      if (ended >= nfr && !tx_busy) fin = 1;
      else begin
        acc = s_valid && s_ready;
        @(posedge eth_tx_clk); #1;
        if (acc) begin
          idx++;
          if (idx == len || (fr == 0 && idx == stop_after)) begin
            fr++; idx = 0;
            if (fr < nfr && stop_after == 0) begin
              s_data = base; s_last = (len == 1);
            end else begin
              s_valid = 1'b0; s_data = '0; s_last = 1'b0;
            end
          end else begin
            s_data = 8'(base + idx); s_last = (idx == len - 1);
          end
        end
      end
    end
    timed_out = !fin;
    en_cycles = 0; done_cnt = 0; abort_cnt = 0; rdy_cnt = 0; rdy_bad = 0;
    last_en = -1; done_idx = -1; abort_idx = -1; gap = -1;
    foreach (tr_en[i]) begin
      if (tr_en[i]) begin en_cycles++; last_en = i; end
      if (tr_done[i]) begin done_cnt++; done_idx = i; end
      if (tr_abort[i]) begin abort_cnt++; abort_idx = i; end
      if (tr_rdy[i]) begin
        rdy_cnt++;
        if (prev >= 0 && i - prev != 2) rdy_bad++;
        prev = i;
      end
    end
    tail_low = tr_en.size() - 1 - last_en;
    for (int i = 1; i < tr_en.size(); i++)
      if (tr_en[i-1] && !tr_en[i]) begin
        int j = i;
        while (j < tr_en.size() && !tr_en[j]) j++;
        if (j < tr_en.size()) gap = j - i;
        break;
      end
  endtask

  task automatic test_reset();
    #5 rstn = 1'b0;
    #30;
    n_chk++;
    if ({eth_tx_en, eth_txd, s_ready, tx_busy, tx_done, tx_abort, frame_cnt} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b txd=%h rdy=%b busy=%b done=%b abort=%b cnt=%0d, expected all 0",
               eth_tx_en, eth_txd, s_ready, tx_busy, tx_done, tx_abort, frame_cnt);
    end
    @(negedge eth_tx_clk); rstn = 1'b1;
    repeat (3) @(negedge eth_tx_clk);
    n_chk++;
    if ({eth_tx_en, tx_busy, s_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got en=%b busy=%b rdy=%b, expected 0 0 0", eth_tx_en, tx_busy, s_ready);
    end
  endtask

  task automatic test_full_frame();
    base = 8'h00;
    drive(1, 60, 0, 600);
    build_exp(60);
    exp_frames++;
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL full_timeout: frame did not finish, expected completion"); end
    n_chk++; if (nib_errs() != 0) begin n_fail++; $display("FAIL full_nibbles: %0d nibbles, %0d errors; expected %0d nibbles, 0 errors", nibs.size(), nib_errs(), exp_n.size()); end
    n_chk++; if (en_cycles != 136 + FCS_NIBS) begin n_fail++; $display("FAIL full_en_len: got %0d, expected %0d", en_cycles, 136 + FCS_NIBS); end
    n_chk++; if (rdy_cnt != 60 || rdy_bad != 0) begin n_fail++; $display("FAIL full_ready: got %0d pulses %0d bad gaps, expected 60 pulses every 2nd cycle", rdy_cnt, rdy_bad); end
    n_chk++; if (done_cnt != 1 || abort_cnt != 0) begin n_fail++; $display("FAIL full_done: got done=%0d abort=%0d, expected 1 0", done_cnt, abort_cnt); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL full_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_short_pad();
    base = 8'hAB;
    drive(1, 1, 0, 600);
    build_exp(1);
    exp_frames++;
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL pad_timeout: frame did not finish, expected completion"); end
    n_chk++; if (en_cycles != 136 + FCS_NIBS) begin n_fail++; $display("FAIL pad_en_len: got %0d, expected %0d", en_cycles, 136 + FCS_NIBS); end
    n_chk++; if (nib_errs() != 0) begin n_fail++; $display("FAIL pad_nibbles: %0d nibbles, %0d errors; expected %0d nibbles, 0 errors", nibs.size(), nib_errs(), exp_n.size()); end
    n_chk++; if (done_cnt != 1 || done_idx != last_en) begin n_fail++; $display("FAIL pad_done_align: got done=%0d at %0d, expected 1 at %0d", done_cnt, done_idx, last_en); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL pad_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_underrun();
    base = 8'h10;
    drive(1, 60, 10, 600);
    build_exp(60);
    exp_n = exp_n[0:35];
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL under_timeout: framer did not return idle"); end
    n_chk++; if (en_cycles != 36 || nib_errs() != 0) begin n_fail++; $display("FAIL under_nibbles: got %0d en cycles %0d errors, expected 36 and 0", en_cycles, nib_errs()); end
    n_chk++; if (abort_cnt != 1 || abort_idx != last_en + 1) begin n_fail++; $display("FAIL under_abort: got %0d pulses at %0d, expected 1 at %0d", abort_cnt, abort_idx, last_en + 1); end
    n_chk++; if (done_cnt != 0 || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL under_count: got done=%0d cnt=%0d, expected 0 and %0d", done_cnt, frame_cnt, exp_frames); end
    n_chk++; if (tail_low != 24) begin n_fail++; $display("FAIL under_ifg: got %0d idle cycles, expected 24", tail_low); end
  endtask

  task automatic test_oversize();
    base = 8'h01;
    drive(1, 2000, 0, 3300);
    build_exp(1514);
    exp_n = exp_n[0:3043];
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL over_timeout: framer did not return idle"); end
    n_chk++; if (en_cycles != 3044 || nib_errs() != 0) begin n_fail++; $display("FAIL over_nibbles: got %0d en cycles %0d errors, expected 3044 and 0", en_cycles, nib_errs()); end
    n_chk++; if (rdy_cnt != 1514) begin n_fail++; $display("FAIL over_ready: got %0d, expected 1514", rdy_cnt); end
    n_chk++; if (abort_cnt != 1 || abort_idx != last_en + 1 || done_cnt != 0) begin n_fail++; $display("FAIL over_abort: got abort=%0d at %0d done=%0d, expected 1 at %0d done 0", abort_cnt, abort_idx, done_cnt, last_en + 1); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL over_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    base = 8'h20;
    drive(2, 60, 0, 800);
    build_exp(60);
    exp_n = {exp_n, exp_n};
    exp_frames += 2;
    n_chk++; if (timed_out) begin n_fail++; $display("FAIL b2b_timeout: frames did not finish"); end
    n_chk++; if (gap != 24) begin n_fail++; $display("FAIL b2b_gap: got %0d low cycles, expected 24", gap); end
    n_chk++; if (nib_errs() != 0) begin n_fail++; $display("FAIL b2b_nibbles: %0d nibbles, %0d errors; expected %0d nibbles, 0 errors", nibs.size(), nib_errs(), exp_n.size()); end
    n_chk++; if (done_cnt != 2 || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL b2b_count: got done=%0d cnt=%0d, expected 2 and %0d", done_cnt, frame_cnt, exp_frames); end
  endtask

  task automatic test_reset_mid_frame();
    @(posedge eth_tx_clk); #1;
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b0;
    repeat (26) @(posedge eth_tx_clk);
    #5;
    n_chk++; if ({eth_tx_en, tx_busy} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got en=%b busy=%b, expected 1 1", eth_tx_en, tx_busy); end
    rstn = 1'b0;
    #1;
    n_chk++; if ({eth_tx_en, s_ready, tx_busy} !== 3'b000) begin n_fail++; $display("FAIL mid_async: got en=%b rdy=%b busy=%b, expected 0 0 0", eth_tx_en, s_ready, tx_busy); end
    n_chk++; if (frame_cnt !== 16'd0 || eth_txd !== 4'h0) begin n_fail++; $display("FAIL mid_clear: got cnt=%0d txd=%h, expected 0 0", frame_cnt, eth_txd); end
    s_valid = 1'b0; s_data = '0;
    #10 rstn = 1'b1;
    exp_frames = 0;
    repeat (2) @(posedge eth_tx_clk); #1;
    base = 8'h30;
    drive(1, 20, 0, 600);
    build_exp(20);
    exp_frames++;
    n_chk++; if (timed_out || nib_errs() != 0) begin n_fail++; $display("FAIL mid_next_frame: timeout=%0d %0d errors, expected 0 0", timed_out, nib_errs()); end
    n_chk++; if (frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL mid_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_len64();
    logic [3:0] exp_last;
    base = 8'h40;
    drive(1, 64, 0, 600);
    build_exp(64);
    exp_frames++;
`ifdef MII_TX_FCS_EN
    exp_last = exp_n[exp_n.size() - 1];
`else
    exp_last = 4'h7;
`endif
    n_chk++; if (en_cycles != 144 + FCS_NIBS) begin n_fail++; $display("FAIL len64_en: got %0d, expected %0d", en_cycles, 144 + FCS_NIBS); end
    n_chk++; if (nibs.size() == 0 || nibs[nibs.size() - 1] !== exp_last) begin n_fail++; $display("FAIL len64_last: got %0d nibbles, last mismatch, expected last %h", nibs.size(), exp_last); end
    n_chk++; if (timed_out || nib_errs() != 0) begin n_fail++; $display("FAIL len64_nibbles: timeout=%0d %0d errors, expected 0 0", timed_out, nib_errs()); end
    n_chk++; if (done_cnt != 1 || frame_cnt !== 16'(exp_frames)) begin n_fail++; $display("FAIL len64_count: got done=%0d cnt=%0d, expected 1 and %0d", done_cnt, frame_cnt, exp_frames); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_pad();
    test_underrun();
    test_oversize();
    test_back_to_back();
    test_reset_mid_frame();
    test_len64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
